// File: rtl/jtkcpu_bus_resp.sv
// jtkcpu_bus_resp: CPU-side bus responder with wait states, backend req/ack handshake and timeout
module jtkcpu_bus_resp #(
    parameter int WAIT = 1,
    parameter int TOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [23:0] addr,
    input  logic        we,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        dtack,
    output logic [23:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        bus_err
);
    localparam logic [1:0] ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2;
    localparam logic [3:0] WAIT_C = 4'(WAIT);
    localparam logic [7:0] TOUT_C = 8'(TOUT);
    logic [1:0]  st_q, st_d;
    logic [3:0]  wcnt_q, wcnt_d, wcnt_inc;
    logic [7:0]  tcnt_q, tcnt_d, tcnt_inc;
    logic        ack_seen_q, ack_seen_d, ack_now;
    logic        dtack_q, dtack_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d, bus_err_q, bus_err_d;
    logic [7:0]  cpu_din_q, cpu_din_d, mem_wdata_q, mem_wdata_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    assign wcnt_inc = (wcnt_q >= WAIT_C) ? wcnt_q : wcnt_q + 4'd1;
    assign tcnt_inc = tcnt_q + 8'd1;
    assign ack_now  = ack_seen_q | mem_ack;
    always_comb begin
        st_d        = st_q;
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        ack_seen_d  = ack_seen_q;
        dtack_d     = dtack_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        bus_err_d   = 1'b0;
        cpu_din_d   = cpu_din_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (st_q)
            ST_IDLE: if (cen) begin
                mem_addr_d  = addr;
                mem_we_d    = we;
                mem_wdata_d = cpu_dout;
                mem_req_d   = 1'b1;
                wcnt_d      = 4'd0;
                tcnt_d      = 8'd0;
                ack_seen_d  = 1'b0;
                st_d        = ST_WAIT;
            end
            ST_WAIT: begin
                wcnt_d = wcnt_inc;
                tcnt_d = tcnt_inc;
                if (mem_ack && !ack_seen_q) begin
                    mem_req_d  = 1'b0;
                    ack_seen_d = 1'b1;
                    cpu_din_d  = mem_we_q ? cpu_din_q : mem_rdata;
                end
                // an ack landing on the timeout cycle takes priority over the error
                if (ack_now && wcnt_inc >= WAIT_C) begin
                    dtack_d = 1'b1;
                    st_d    = ST_DONE;
                end else if (!ack_now && tcnt_inc == TOUT_C) begin
                    mem_req_d = 1'b0;
                    cpu_din_d = 8'hFF;
                    bus_err_d = 1'b1;
                    dtack_d   = 1'b1;
                    st_d      = ST_DONE;
                end
            end
            ST_DONE: if (cen) begin
                dtack_d = 1'b0;
                st_d    = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            wcnt_q      <= 4'd0;
            tcnt_q      <= 8'd0;
            ack_seen_q  <= 1'b0;
            dtack_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            cpu_din_q   <= 8'd0;
            mem_addr_q  <= 24'd0;
            mem_wdata_q <= 8'd0;
        end else begin
            st_q        <= st_d;
            wcnt_q      <= wcnt_d;
            tcnt_q      <= tcnt_d;
            ack_seen_q  <= ack_seen_d;
            dtack_q     <= dtack_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            bus_err_q   <= bus_err_d;
            cpu_din_q   <= cpu_din_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end
    assign cpu_din   = cpu_din_q;
    assign dtack     = dtack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_req   = mem_req_q;
    assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_jtkcpu_bus_resp.sv
// tb_jtkcpu_bus_resp: randomized accesses checked against a per-access latency model
module tb_jtkcpu_bus_resp;
    localparam int WAIT_N = 4;
    localparam int TOUT_N = 16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic [23:0] addr = 24'd0;
    logic        we = 1'b0;
    logic [7:0]  cpu_dout = 8'd0;
    logic [7:0]  cpu_din;
    logic        dtack;
    logic [23:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'd0;
    logic        bus_err;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [7:0]  exp_din = 8'd0;

    jtkcpu_bus_resp #(.WAIT(WAIT_N), .TOUT(TOUT_N)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .addr(addr), .we(we), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .dtack(dtack), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // lat: edge index (1 = first edge after capture) at which mem_ack is presented
    task automatic access(input logic [23:0] a, input logic w, input logic [7:0] wd,
                          input int lat, input logic [7:0] rd, input int hold);
        int e;
        e = (lat <= TOUT_N) ? ((lat > WAIT_N) ? lat : WAIT_N) : TOUT_N;
        addr = a; we = w; cpu_dout = wd; cen = 1'b1; mem_ack = 1'b0;
        step;
        chk("cap_req", mem_req, 1);
        chk("cap_addr", mem_addr, a);
        chk("cap_we", mem_we, w);
        chk("cap_wdata", mem_wdata, wd);
        chk("cap_dtack", dtack, 0);
        for (int k = 1; k <= e; k++) begin
            cen = 1'($urandom);
            mem_ack = (k == lat);
            mem_rdata = (k == lat) ? rd : 8'($urandom);
            step;
            chk("wait_req", mem_req, (k < lat && k < TOUT_N));
            chk("wait_berr", bus_err, (lat > TOUT_N && k == TOUT_N));
            chk("wait_dtack", dtack, k >= e);
            chk("wait_addr", mem_addr, a);
        end
        exp_din = (lat > TOUT_N) ? 8'hFF : (w ? exp_din : rd);
        chk("done_din", cpu_din, exp_din);
        for (int h = 0; h < hold; h++) begin
            cen = 1'b0;
            mem_ack = 1'($urandom);
            mem_rdata = 8'($urandom);
            step;
            chk("hold_dtack", dtack, 1);
            chk("hold_din", cpu_din, exp_din);
            chk("hold_req", mem_req, 0);
            chk("hold_berr", bus_err, 0);
        end
        cen = 1'b1;
        mem_ack = 1'($urandom);
        step;
        chk("rel_dtack", dtack, 0);
        chk("rel_req", mem_req, 0);
        chk("rel_din", cpu_din, exp_din);
        cen = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dtack", dtack, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_berr", bus_err, 0);
        chk("rst_din", cpu_din, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        step;
        chk("idle_req", mem_req, 0);
        access(24'h00ABCD, 1'b0, 8'h00, 2, 8'h5A, 3);
        access(24'h123456, 1'b1, 8'hC3, 5, 8'h77, 0);
        access(24'h000010, 1'b0, 8'h00, 1, 8'h3C, 1);
        access(24'hFFFFFF, 1'b0, 8'h00, 30, 8'h11, 4);
        access(24'h000020, 1'b0, 8'h00, 3, 8'h96, 10);
        access(24'h000020, 1'b0, 8'h00, TOUT_N, 8'h69, 2);
        // abandon an access mid-wait with an asynchronous reset
        addr = 24'h0BEEF0; we = 1'b0; cen = 1'b1;
        step;
        cen = 1'b0;
        step;
        step;
        chk("mid_req_pre", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_req", mem_req, 0);
        chk("mid_dtack", dtack, 0);
        chk("mid_berr", bus_err, 0);
        chk("mid_din", cpu_din, 0);
        exp_din = 8'd0;
        step;
        rst_n = 1'b1;
        step;
        access(24'h0BEEF0, 1'b0, 8'h00, 6, 8'hE1, 2);
        for (int i = 0; i < 40; i++) begin
            int gap;
            access(24'($urandom), 1'($urandom), 8'($urandom), $urandom_range(1, 20),
                   8'($urandom), $urandom_range(0, 4));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                mem_ack = 1'($urandom);
                step;
                chk("gap_req", mem_req, 0);
                chk("gap_dtack", dtack, 0);
            end
            mem_ack = 1'b0;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
